// File: rtl/dir_input_queue.sv
// Direction input queue: four synchronised, debounced pushbuttons feed a
// small FIFO of headings that is committed to dir one entry per game tick.
module dir_input_queue #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEPTH      = 4
) (
  input  logic                     CLK_100MHz,
  input  logic                     rst,
  input  logic                     gameOver,
  input  logic                     Up,
  input  logic                     Right,
  input  logic                     Down,
  input  logic                     Left,
  input  logic                     step,
  output logic [1:0]               dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [NW-1:0] FULL    = NW'(DEPTH);

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_stable;
  logic [3:0]    r_stable_d;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_press;

  logic [1:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [NW-1:0] r_count;
  logic [1:0]    r_dir;
  logic          r_ovf;

  logic          w_cand_v;
  logic [1:0]    w_cand;
  logic [PW-1:0] w_tail;
  logic [1:0]    w_ref;
  logic          w_rej;
  logic          w_full;
  logic          w_pop;
  logic          w_acc;
  logic          w_push;
  logic          w_drop;

  // Bit index doubles as the heading code of that button.
  assign w_raw = {Left, Down, Right, Up};

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  always_comb begin
    w_cand_v = |w_press;
    w_cand   = 2'd0;
    if (w_press[0])      w_cand = 2'd0;
    else if (w_press[1]) w_cand = 2'd1;
    else if (w_press[2]) w_cand = 2'd2;
    else if (w_press[3]) w_cand = 2'd3;
  end

  // Compare against the newest pending heading, not the committed one.
  assign w_tail = r_wp - PW'(1);
  assign w_ref  = (r_count != '0) ? r_mem[w_tail] : r_dir;
  assign w_rej  = (w_cand == w_ref) || ((w_cand ^ w_ref) == 2'b10);
  assign w_full = (r_count == FULL);
  assign w_pop  = step && (r_count != '0);
  assign w_acc  = w_cand_v && !w_rej;
  assign w_push = w_acc && (!w_full || w_pop);
  assign w_drop = w_acc && w_full && !w_pop;

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_dir   <= '0;
      r_ovf   <= 1'b0;
    end else if (gameOver) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_dir   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_cand;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_dir <= r_mem[r_rp];
        r_rp  <= r_rp + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + NW'(1);
      else if (w_pop && !w_push) r_count <= r_count - NW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign dir      = r_dir;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule
